// File: rtl/uart_rx_os16.sv
// Purpose: 16x-oversampling UART receiver, 8 data bits LSB-first, 1 stop bit, 3-sample majority vote.
// Latency: rx_valid rises about (9*16+10)*DIV + 3 clk after the start-bit falling edge (one bit later with parity).
// Backpressure: none on the line; a one-entry buffer drops a new byte and flags overrun while unread.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         serial line, idle high, asynchronous to clk
//   rx_rd      host read strobe, consumes the buffered byte
//   rx_data    last accepted byte, stable while rx_valid is high
//   rx_valid   buffer holds an unread byte
//   overrun    sticky, a byte was dropped because the buffer was full
//   frame_err  one-cycle pulse, stop bit sampled low
//   parity_err one-cycle pulse, even-parity mismatch (tied low without parity)
//   busy       receiver is not idle
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit between D7
// and the stop bit; undefined gives plain 10-bit frames and parity_err = 0.

module uart_rx_os16 #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_rd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       overrun,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    // Clocks per oversampling tick; must come out at 2 or more.
    localparam int DIV = clk_freq / (baud_rate * 16);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input synchronizer. rxs_prev is one more stage, used only to spot
    // the 1->0 start edge on the synchronized line.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;
    logic rxs_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    logic start_det;
    assign start_det = (state == S_IDLE) && rxs_prev && !rxs;

    // ------------------------------------------------------------------
    // Oversampling tick generator and sample counter. Both are cleared
    // on the start edge so that sc=8 lands near the middle of each bit.
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    sc;

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sc      <= 4'd0;
        end else if (start_det) begin
            div_cnt <= '0;
            sc      <= 4'd0;
        end else if (tick) begin
            div_cnt <= '0;
            sc      <= sc + 4'd1;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Majority vote: samples at sc=7 and sc=8 are held, the third is the
    // live line value at the sc=9 tick, which is where every decision
    // that uses the vote is taken.
    // ------------------------------------------------------------------
    logic samp7;
    logic samp8;
    logic vote;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp7 <= 1'b1;
            samp8 <= 1'b1;
        end else if (tick) begin
            if (sc == 4'd7) samp7 <= rxs;
            if (sc == 4'd8) samp8 <= rxs;
        end
    end

    assign vote = (samp7 & samp8) | (samp7 & rxs) | (samp8 & rxs);

    logic at_mid;
    logic at_end;
    assign at_mid = tick && (sc == 4'd9);
    assign at_end = tick && (sc == 4'd15);

    // ------------------------------------------------------------------
    // Frame FSM with the receive buffer and status flags.
    // ------------------------------------------------------------------
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic       parity_err_r;
`ifdef UART_RX_PARITY_EN
    logic       par_bad;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            shreg        <= 8'h00;
            bit_idx      <= 3'd0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            overrun      <= 1'b0;
            frame_err    <= 1'b0;
            parity_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
`endif
        end else begin
            frame_err    <= 1'b0;
            parity_err_r <= 1'b0;

            // Host read. An accept in the same cycle overrides rx_valid
            // below, so the new byte replaces the one being read.
            if (rx_rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start_det) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (at_mid && vote) begin
                        // Line back high by mid start bit: glitch, not a frame.
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (at_end) begin
                        state   <= S_DATA;
                        bit_idx <= 3'd0;
                    end
                end

                S_DATA: begin
                    if (at_mid) begin
                        shreg <= {vote, shreg[7:1]};
                    end
                    if (at_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (at_mid) begin
                        // Even parity: the parity bit equals the XOR of the data.
                        par_bad <= vote ^ (^shreg);
                    end
                    if (at_end) begin
                        state <= S_STOP;
                    end
                end
`endif

                S_STOP: begin
                    if (at_mid) begin
                        if (!vote) begin
                            // Stop bit low; wait for the line to recover so a
                            // held-low (break) line cannot start a new frame.
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err_r <= 1'b1;
                            end else
`endif
                            if (rx_valid && !rx_rd) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                end

                S_BREAK: begin
                    if (rxs) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule
